// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared types and defaults for the instruction fetch unit
package if_fetch_pkg;
  typedef enum logic [1:0] {S_REQ, S_PEND, S_DROP} fetch_state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with one-entry pending buffer, stall and redirect handling
module if_fetch_unit
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk_IF,
  input  logic        rst_IF,
  input  logic        stall_IF,
  input  logic        redirect_IF,
  input  logic [31:0] redirect_PC_IF,
  output logic        imem_req_IF,
  output logic [31:0] imem_addr_IF,
  input  logic        imem_ack_IF,
  input  logic [31:0] imem_rdata_IF,
  output logic [31:0] PC_out_IF,
  output logic [31:0] inst_out_IF,
  output logic        valid_IF
);
  fetch_state_t state, state_nxt;
  logic [31:0] pc, pend_pc, pend_inst, drop_addr;
  logic take, slot_free;
  assign take = state == S_REQ && imem_ack_IF;
  assign slot_free = !valid_IF || !stall_IF;
  // request outputs and next state; a redirect while a request is still open must drain it in DROP
  always_comb begin
    imem_req_IF = state != S_PEND;
    imem_addr_IF = state == S_DROP ? drop_addr : pc;
    state_nxt = state;
    if (redirect_IF)
      state_nxt = (state == S_DROP || (state == S_REQ && !imem_ack_IF)) ? S_DROP : S_REQ;
    else if (state == S_REQ)
      state_nxt = (imem_ack_IF && !slot_free) ? S_PEND : S_REQ;
    else if (state == S_PEND)
      state_nxt = stall_IF ? S_PEND : S_REQ;
    else
      state_nxt = imem_ack_IF ? S_REQ : S_DROP;
  end
  // state register
  always_ff @(posedge clk_IF)
    state <= rst_IF ? S_REQ : state_nxt;
  // fetch pc, pending buffer and IF/ID output slot
  always_ff @(posedge clk_IF) begin
    if (rst_IF) begin
      pc <= RESET_PC;
      drop_addr <= '0;
      pend_pc <= '0;
      pend_inst <= NOP_INST;
      valid_IF <= 1'b0;
      PC_out_IF <= '0;
      inst_out_IF <= NOP_INST;
    end else if (redirect_IF) begin
      if (state == S_REQ && !imem_ack_IF) drop_addr <= pc;
      pc <= redirect_PC_IF & ~32'd3;
      pend_pc <= '0;
      pend_inst <= NOP_INST;
      valid_IF <= 1'b0;
      PC_out_IF <= '0;
      inst_out_IF <= NOP_INST;
    end else begin
      if (take) pc <= pc + PC_STEP;
      if (take && slot_free) begin
        PC_out_IF <= pc;
        inst_out_IF <= imem_rdata_IF;
        valid_IF <= 1'b1;
      end else if (take) begin
        pend_pc <= pc;
        pend_inst <= imem_rdata_IF;
      end else if (state == S_PEND && !stall_IF) begin
        PC_out_IF <= pend_pc;
        inst_out_IF <= pend_inst;
        valid_IF <= 1'b1;
      end else if (valid_IF && !stall_IF) begin
        PC_out_IF <= '0;
        inst_out_IF <= NOP_INST;
        valid_IF <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: random and directed checks of the fetch unit against a queue-based model
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk_IF = 0;
  logic rst_IF = 0, stall_IF = 0, redirect_IF = 0, imem_ack_IF = 0;
  logic [31:0] redirect_PC_IF = 0, imem_rdata_IF = 0;
  logic imem_req_IF, valid_IF;
  logic [31:0] imem_addr_IF, PC_out_IF, inst_out_IF;
  int passed = 0, total = 0;
  int lat = 0, cur_lat = 0, cnt = 0;
  bit rnd_lat = 0;
  logic [31:0] m_fa = 0, m_da = 0, m_pc = 0, m_inst = NOP;
  bit m_disc = 0, m_v = 0;
  logic [63:0] m_buf[$];

  always #5 clk_IF = ~clk_IF;

  if_fetch_unit dut (
    .clk_IF(clk_IF), .rst_IF(rst_IF), .stall_IF(stall_IF), .redirect_IF(redirect_IF),
    .redirect_PC_IF(redirect_PC_IF), .imem_req_IF(imem_req_IF), .imem_addr_IF(imem_addr_IF),
    .imem_ack_IF(imem_ack_IF), .imem_rdata_IF(imem_rdata_IF), .PC_out_IF(PC_out_IF),
    .inst_out_IF(inst_out_IF), .valid_IF(valid_IF)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s got %h want %h", name, got, want);
  endtask

  task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] rpc);
    bit a, mreq, dreq;
    if (cnt == 0) cur_lat = rnd_lat ? int'($urandom_range(0, 3)) : lat;
    dreq = imem_req_IF === 1'b1;
    a = dreq && cnt >= cur_lat;
    rst_IF = r; stall_IF = s; redirect_IF = rd; redirect_PC_IF = rpc; imem_ack_IF = a;
    imem_rdata_IF = a ? memf(imem_addr_IF) : $urandom;
    mreq = m_buf.size() == 0;
    if (r) begin
      m_fa = 32'h0; m_disc = 0; m_da = 0; m_buf.delete(); m_v = 0; m_pc = 0; m_inst = NOP;
    end else if (rd) begin
      if (!m_disc && mreq && !a) begin m_disc = 1; m_da = m_fa; end
      m_fa = {rpc[31:2], 2'b00}; m_buf.delete(); m_v = 0; m_pc = 0; m_inst = NOP;
    end else if (mreq && a && m_disc) m_disc = 0;
    else if (mreq && a) begin
      if (!m_v || !s) begin m_v = 1; m_pc = m_fa; m_inst = memf(m_fa); end
      else m_buf.push_back({m_fa, memf(m_fa)});
      m_fa = m_fa + 32'd4;
    end else if (m_buf.size() > 0) begin
      if (!s) begin {m_pc, m_inst} = m_buf.pop_front(); m_v = 1; end
    end else if (m_v && !s) begin m_v = 0; m_pc = 0; m_inst = NOP; end
    @(posedge clk_IF);
    #1;
    cnt = (r || a) ? 0 : dreq ? cnt + 1 : cnt;
    chk("valid", {31'b0, valid_IF}, {31'b0, m_v});
    chk("pc_out", PC_out_IF, m_pc);
    chk("inst_out", inst_out_IF, m_inst);
    chk("req", {31'b0, imem_req_IF}, {31'b0, m_buf.size() == 0});
    if (m_buf.size() == 0) chk("addr", imem_addr_IF, m_disc ? m_da : m_fa);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] exp_pcs [3];
    do_reset();
    chk("rst_valid", {31'b0, valid_IF}, 32'd0);
    chk("rst_inst", inst_out_IF, 32'h0000_0013);
    chk("rst_addr", imem_addr_IF, 32'h0);
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      chk("zw_pc", PC_out_IF, 32'(i * 4));
      chk("zw_valid", {31'b0, valid_IF}, 32'd1);
    end
    do_reset();
    lat = 2;
    exp_pcs = '{32'h0, 32'h4, 32'h8};
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0);
      chk("w2_addr_held", imem_addr_IF, exp_pcs[k]);
      step(0, 0, 0, 0);
      chk("w2_invalid", {31'b0, valid_IF}, 32'd0);
      step(0, 0, 0, 0);
      chk("w2_pc", PC_out_IF, exp_pcs[k]);
    end
    do_reset();
    lat = 0;
    repeat (3) step(0, 0, 0, 0);
    chk("st_pre", PC_out_IF, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("st_hold", PC_out_IF, 32'h8);
      chk("st_req_low", {31'b0, imem_req_IF}, 32'd0);
    end
    step(0, 0, 0, 0);
    chk("st_resume12", PC_out_IF, 32'hC);
    step(0, 0, 0, 0);
    chk("st_resume16", PC_out_IF, 32'h10);
    do_reset();
    repeat (4) step(0, 0, 0, 0);
    lat = 2;
    step(0, 0, 1, 32'h0000_0101);
    chk("drop_addr", imem_addr_IF, 32'h10);
    chk("drop_valid", {31'b0, valid_IF}, 32'd0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("drop_done_addr", imem_addr_IF, 32'h100);
    chk("drop_done_valid", {31'b0, valid_IF}, 32'd0);
    repeat (3) step(0, 0, 0, 0);
    chk("drop_target_pc", PC_out_IF, 32'h100);
    do_reset();
    lat = 0;
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0040);
    chk("rack_inst", inst_out_IF, 32'h0000_0013);
    chk("rack_valid", {31'b0, valid_IF}, 32'd0);
    chk("rack_addr", imem_addr_IF, 32'h40);
    step(0, 0, 0, 0);
    chk("rack_pc", PC_out_IF, 32'h40);
    step(0, 1, 0, 0);
    chk("pend_req", {31'b0, imem_req_IF}, 32'd0);
    step(1, 1, 1, 32'h0000_0800);
    chk("rpend_valid", {31'b0, valid_IF}, 32'd0);
    chk("rpend_inst", inst_out_IF, 32'h0000_0013);
    chk("rpend_addr", imem_addr_IF, 32'h0);
    step(0, 0, 1, 32'hFFFF_FFF9);
    step(0, 0, 0, 0);
    chk("wrap_f8", PC_out_IF, 32'hFFFF_FFF8);
    step(0, 0, 0, 0);
    chk("wrap_fc", PC_out_IF, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap_0", PC_out_IF, 32'h0);
    rnd_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 5, rpc);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
